// File: rtl/mini_alu.sv
// Single-cycle 16-bit mini processor: fixed 256-word ROM, 8x16 register file,
// one instruction per rising edge, result shown on an 8-bit LED register.
module mini_alu (
  input  logic       Clock,
  input  logic       Reset,
  output logic [7:0] oLed
);

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LED = 8'h01;
  localparam logic [7:0] OP_STO = 8'h02;
  localparam logic [7:0] OP_ADD = 8'h03;
  localparam logic [7:0] OP_SUB = 8'h04;
  localparam logic [7:0] OP_BLE = 8'h05;
  localparam logic [7:0] OP_JMP = 8'h06;

  // Program store: {op, dst, src1, src0}; unlisted addresses hold NOP.
  function automatic logic [31:0] rom_word(input logic [7:0] addr);
    case (addr)
      8'd0:    rom_word = {OP_STO, 8'd1, 16'h0001};
      8'd1:    rom_word = {OP_STO, 8'd2, 16'h0000};
      8'd2:    rom_word = {OP_STO, 8'd4, 16'h0003};
      8'd3:    rom_word = {OP_LED, 8'd0, 8'd0, 8'd2};
      8'd4:    rom_word = {OP_ADD, 8'd2, 8'd2, 8'd1};
      8'd5:    rom_word = {OP_BLE, 8'd3, 8'd2, 8'd4};
      8'd6:    rom_word = {OP_STO, 8'd2, 16'h0000};
      8'd7:    rom_word = {OP_JMP, 8'd3, 16'h0000};
      default: rom_word = {OP_NOP, 24'h000000};
    endcase
  endfunction

  logic [7:0]       pc_q, pc_d;
  logic [7:0][15:0] rf_q, rf_d;
  logic [7:0]       led_q, led_d;

  logic [31:0] instr_s;
  logic [7:0]  op_s, dst_s, src1_s, src0_s;
  logic [15:0] opa_s, opb_s;

  assign instr_s = rom_word(pc_q);
  assign op_s    = instr_s[31:24];
  assign dst_s   = instr_s[23:16];
  assign src1_s  = instr_s[15:8];
  assign src0_s  = instr_s[7:0];
  assign opa_s   = rf_q[src1_s[2:0]];
  assign opb_s   = rf_q[src0_s[2:0]];

  // Decode and execute the fetched instruction; unknown opcodes fall to NOP.
  always_comb begin
    pc_d  = pc_q + 8'd1;
    rf_d  = rf_q;
    led_d = led_q;
    case (op_s)
      OP_NOP: ;
      OP_LED: led_d = opb_s[7:0];
      OP_STO: rf_d[dst_s[2:0]] = {src1_s, src0_s};
      OP_ADD: rf_d[dst_s[2:0]] = opa_s + opb_s;
      OP_SUB: rf_d[dst_s[2:0]] = opa_s - opb_s;
      OP_BLE: begin
        if (opa_s <= opb_s) begin
          pc_d = dst_s;
        end else begin
          pc_d = pc_q + 8'd1;
        end
      end
      OP_JMP: pc_d = dst_s;
      default: ;
    endcase
  end

  // Architectural state update with asynchronous clear.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pc_q  <= 8'h00;
      rf_q  <= '0;
      led_q <= 8'h00;
    end else begin
      pc_q  <= pc_d;
      rf_q  <= rf_d;
      led_q <= led_d;
    end
  end

  assign oLed = led_q;

endmodule

// File: tb/tb_mini_alu.sv
// Scoreboard bench for mini_alu: a program-level reference model predicts the
// state after every edge; a negedge monitor compares it with the DUT.
module tb_mini_alu;

  logic       Clock;
  logic       Reset;
  logic [7:0] oLed;
  logic       clk_en;

  mini_alu dut (
    .Clock (Clock),
    .Reset (Reset),
    .oLed  (oLed)
  );

  typedef struct packed {
    logic [7:0]       led;
    logic [7:0]       pc;
    logic [7:0][15:0] r;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   edge_no = 0;
  bit   chk_on = 1'b0;

  int m_pc;
  int m_led;
  int m_r[8];

  initial begin
    Clock = 1'b0;
    forever begin
      #5;
      if (clk_en) Clock = ~Clock;
      else Clock = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, expv, edge_no);
    end
  endtask

  task automatic model_reset();
    m_pc = 0;
    m_led = 0;
    for (int i = 0; i < 8; i++) m_r[i] = 0;
  endtask

  // Semantics of the fixed program, one instruction at a time.
  task automatic model_step();
    case (m_pc)
      0: begin m_r[1] = 1; m_pc = 1; end
      1: begin m_r[2] = 0; m_pc = 2; end
      2: begin m_r[4] = 3; m_pc = 3; end
      3: begin m_led = m_r[2] % 256; m_pc = 4; end
      4: begin m_r[2] = (m_r[2] + m_r[1]) % 65536; m_pc = 5; end
      5: m_pc = (m_r[2] <= m_r[4]) ? 3 : 6;
      6: begin m_r[2] = 0; m_pc = 7; end
      7: m_pc = 3;
      default: m_pc = (m_pc + 1) % 256;
    endcase
  endtask

  function automatic exp_t model_snapshot();
    exp_t e;
    e.led = m_led[7:0];
    e.pc  = m_pc[7:0];
    for (int i = 0; i < 8; i++) e.r[i] = m_r[i][15:0];
    return e;
  endfunction

  task automatic directed();
    if (chk_on && Reset) begin
      case (edge_no)
        3: begin
          chk("e3_r1", int'(dut.rf_q[1]), 1);
          chk("e3_r2", int'(dut.rf_q[2]), 0);
          chk("e3_r4", int'(dut.rf_q[4]), 3);
          for (int i = 0; i < 8; i++)
            if (i != 1 && i != 2 && i != 4) chk($sformatf("e3_r%0d", i), int'(dut.rf_q[i]), 0);
        end
        4:  chk("e4_led", int'(oLed), 0);
        7:  chk("e7_led", int'(oLed), 1);
        10: chk("e10_led", int'(oLed), 2);
        12: chk("e12_ble_taken_pc", int'(dut.pc_q), 3);
        13, 14, 17: chk("e13_17_led", int'(oLed), 3);
        15: begin
          chk("e15_ble_fall_pc", int'(dut.pc_q), 6);
          chk("e15_led", int'(oLed), 3);
        end
        16: begin
          chk("e16_r2_clear", int'(dut.rf_q[2]), 0);
          chk("e16_led", int'(oLed), 3);
        end
        18: chk("e18_led_wrap", int'(oLed), 0);
        21: chk("e21_led", int'(oLed), 1);
        default: ;
      endcase
    end
  endtask

  // Issue one edge: advance the model and queue its expected state.
  task automatic run_edge();
    @(posedge Clock);
    #1;
    if (Reset) begin
      model_step();
      edge_no++;
    end else begin
      model_reset();
    end
    exp_q.push_back(model_snapshot());
    directed();
  endtask

  task automatic assert_reset_now();
    Reset = 1'b0;
    model_reset();
    edge_no = 0;
    #1;
    chk("async_led", int'(oLed), 0);
    chk("async_pc", int'(dut.pc_q), 0);
    chk("async_r2", int'(dut.rf_q[2]), 0);
  endtask

  // Monitor: compare queued expectations against the DUT away from the edge.
  always @(negedge Clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_led", int'(oLed), int'(e.led));
      chk("sb_pc", int'(dut.pc_q), int'(e.pc));
      for (int i = 0; i < 8; i++)
        chk($sformatf("sb_r%0d", i), int'(dut.rf_q[i]), int'(e.r[i]));
      chk("sb_led_range", int'(oLed <= 8'd3), 1);
    end
  end

  initial begin
    clk_en = 1'b0;
    Reset  = 1'b1;
    model_reset();
    #3;
    Reset = 1'b0;
    #1;
    chk("rst_led", int'(oLed), 0);
    chk("rst_pc", int'(dut.pc_q), 0);
    chk("rst_r1", int'(dut.rf_q[1]), 0);
    chk("rst_r2", int'(dut.rf_q[2]), 0);
    chk("rst_r4", int'(dut.rf_q[4]), 0);

    clk_en = 1'b1;
    run_edge();
    run_edge();
    #1 Reset = 1'b1;
    chk_on = 1'b1;

    while (edge_no < 11) run_edge();
    @(negedge Clock);
    #1;
    assert_reset_now();
    for (int i = 0; i < 3; i++) run_edge();
    #1 Reset = 1'b1;
    while (edge_no < 21) run_edge();
    chk_on = 1'b0;

    for (int k = 0; k < 6; k++) begin
      int n_run;
      int n_hold;
      n_run  = int'($urandom_range(10, 60));
      n_hold = int'($urandom_range(1, 3));
      for (int i = 0; i < n_run; i++) run_edge();
      #($urandom_range(5, 7));
      assert_reset_now();
      for (int i = 0; i < n_hold; i++) run_edge();
      #1 Reset = 1'b1;
    end

    for (int i = 0; i < 200; i++) run_edge();

    @(negedge Clock);
    #1;
    clk_en = 1'b0;
    #20;
    chk("idle_pre_led_range", int'(oLed <= 8'd3), 1);
    assert_reset_now();
    chk("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
